key_command_scheduler: RTL and testbench

- Sits between keyboard_tracker (hold mode) and the Minesweeper game FSM.
- Converts held key levels into a single serialized command stream with a valid/ready handshake.
- Detects key presses and adds typematic auto-repeat to direction keys.
- Arbitrates simultaneous events by fixed priority and buffers commands in a small FIFO, so the game FSM can stall without losing moves.

---
 rtl/key_command_scheduler_pkg.sv | 53 +++++
 rtl/key_command_scheduler_fifo.sv | 53 +++++
 rtl/key_command_scheduler.sv | 132 +++++++++++++
 tb/tb_key_command_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_command_scheduler_pkg.sv
// Shared command codes, key indices, priority order and repeat FSM encoding
// for the keyboard command scheduler.
package key_cmd_pkg;

    localparam int CMD_W    = 3;
    localparam int NUM_KEYS = 7;

    // Key index equals its command code, so a pending bit maps directly to a code.
    localparam logic [CMD_W-1:0] CMD_UP     = 3'd0;
    localparam logic [CMD_W-1:0] CMD_DOWN   = 3'd1;
    localparam logic [CMD_W-1:0] CMD_LEFT   = 3'd2;
    localparam logic [CMD_W-1:0] CMD_RIGHT  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_REVEAL = 3'd4;
    localparam logic [CMD_W-1:0] CMD_FLAG   = 3'd5;
    localparam logic [CMD_W-1:0] CMD_ENTER  = 3'd6;

    localparam int K_UP     = 0;
    localparam int K_DOWN   = 1;
    localparam int K_LEFT   = 2;
    localparam int K_RIGHT  = 3;
    localparam int K_REVEAL = 4;
    localparam int K_FLAG   = 5;
    localparam int K_ENTER  = 6;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rpt_state_e;

    // ENTER > REVEAL > FLAG > UP > DOWN > LEFT > RIGHT
    function automatic logic [CMD_W-1:0] prio_pick(input logic [NUM_KEYS-1:0] p);
        logic [CMD_W-1:0] r;
        if (p[K_ENTER])       r = CMD_ENTER;
        else if (p[K_REVEAL]) r = CMD_REVEAL;
        else if (p[K_FLAG])   r = CMD_FLAG;
        else if (p[K_UP])     r = CMD_UP;
        else if (p[K_DOWN])   r = CMD_DOWN;
        else if (p[K_LEFT])   r = CMD_LEFT;
        else                  r = CMD_RIGHT;
        return r;
    endfunction

    function automatic logic [1:0] dir_pick(input logic [3:0] e);
        logic [1:0] r;
        if (e[K_UP])        r = 2'd0;
        else if (e[K_DOWN]) r = 2'd1;
        else if (e[K_LEFT]) r = 2'd2;
        else                r = 2'd3;
        return r;
    endfunction

endpackage

// File: rtl/key_command_scheduler_fifo.sv
// First-word fall-through FIFO; dout shows the head and reads 0 while empty.
module cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q + PTR_W'(do_push);
        rd_d  = rd_q + PTR_W'(do_pop);
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/key_command_scheduler.sv
// Turns held key levels into a prioritised, buffered command stream with
// typematic auto-repeat on the four direction keys.
module key_command_scheduler
    import key_cmd_pkg::*;
#(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_up,
    input  logic             key_down,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_space,
    input  logic             key_flag,
    input  logic             key_enter,
    // cmd_code is meaningful while cmd_valid is high and holds until consumed;
    // the head is consumed in every cycle where cmd_valid and cmd_ready are both high.
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd_code,
    input  logic             cmd_ready,
    output logic             overflow,
    output logic             repeat_active
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE - 1);

    logic [NUM_KEYS-1:0] key_vec, key_q, key_d, edge_vec;
    logic [NUM_KEYS-1:0] pend_q, pend_d, rpt_ev, ev, clr;
    logic                ovf_q, ovf_d;
    logic [3:0]          dir_vec, dir_edge;

    rpt_state_e          state_q, state_d;
    logic [1:0]          rpt_key_q, rpt_key_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rpt_fire;

    logic                fifo_push, fifo_full, fifo_empty, pop;
    logic [CMD_W-1:0]    push_code;

    assign key_vec  = {key_enter, key_flag, key_space, key_right, key_left, key_down, key_up};
    assign key_d    = key_vec;
    assign edge_vec = key_vec & ~key_q;
    assign dir_vec  = key_vec[3:0];
    assign dir_edge = edge_vec[3:0];

    always_comb begin
        state_d   = state_q;
        rpt_key_d = rpt_key_q;
        cnt_d     = cnt_q;
        rpt_fire  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (|dir_edge) begin
                    rpt_key_d = dir_pick(dir_edge);
                    cnt_d     = DELAY_LD;
                    state_d   = R_DELAY;
                end
            end
            R_DELAY, R_REPEAT: begin
                if (!dir_vec[rpt_key_q]) begin
                    state_d = R_IDLE;
                end else if (|dir_edge) begin
                    rpt_key_d = dir_pick(dir_edge);
                    cnt_d     = DELAY_LD;
                    state_d   = R_DELAY;
                end else if (cnt_q == '0) begin
                    rpt_fire = 1'b1;
                    cnt_d    = RATE_LD;
                    state_d  = R_REPEAT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Clearing happens before setting, so a re-event on the bit being pushed is not a merge.
    always_comb begin
        rpt_ev    = rpt_fire ? NUM_KEYS'(4'b0001 << rpt_key_q) : '0;
        ev        = edge_vec | rpt_ev;
        push_code = prio_pick(pend_q);
        fifo_push = (|pend_q) & (~fifo_full | pop);
        clr       = fifo_push ? NUM_KEYS'(8'b0000_0001 << push_code) : '0;
        pend_d    = (pend_q & ~clr) | ev;
        ovf_d     = ovf_q | (|(ev & pend_q & ~clr));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_q     <= '0;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
            state_q   <= R_IDLE;
            rpt_key_q <= '0;
            cnt_q     <= '0;
        end else begin
            key_q     <= key_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            rpt_key_q <= rpt_key_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd_valid     = ~fifo_empty;
    assign pop           = cmd_valid & cmd_ready;
    assign overflow      = ovf_q;
    assign repeat_active = (state_q != R_IDLE);

    cmd_fifo #(
        .WIDTH(CMD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (fifo_push),
        .din  (push_code),
        .full (fifo_full),
        .pop  (pop),
        .dout (cmd_code),
        .empty(fifo_empty)
    );

endmodule

// File: tb/tb_key_command_scheduler.sv
// Directed and random stimulus for key_command_scheduler, checked every cycle
// against a queue-based behavioural model of the command stream.
module tb_key_command_scheduler;

    localparam int DELAY = 10;
    localparam int RATE  = 4;
    localparam int DEPTH = 4;

    logic       clock;
    logic       reset;
    logic [6:0] keys;
    logic       ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       overflow;
    logic       repeat_active;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [2:0] exp_q[$];
    logic [2:0] got_q[$];
    logic [6:0] m_prev;
    logic [6:0] m_pend;
    logic       m_ovf;
    int         m_rpt;
    int         m_t0;
    int         m_cyc;
    int         prio_order[7] = '{6, 4, 5, 0, 1, 2, 3};

    key_command_scheduler #(
        .REPEAT_DELAY(DELAY),
        .REPEAT_RATE (RATE),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_up       (keys[0]),
        .key_down     (keys[1]),
        .key_left     (keys[2]),
        .key_right    (keys[3]),
        .key_space    (keys[4]),
        .key_flag     (keys[5]),
        .key_enter    (keys[6]),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .cmd_ready    (ready),
        .overflow     (overflow),
        .repeat_active(repeat_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input int n, input int c0 = 0, input int c1 = 0,
                           input int c2 = 0, input int c3 = 0, input int c4 = 0, input int c5 = 0);
        int e[6];
        e = '{c0, c1, c2, c3, c4, c5};
        chk({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk($sformatf("%s_cmd%0d", tag, i), got_q[i], e[i]);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev = '0;
        m_pend = '0;
        m_ovf  = 1'b0;
        m_rpt  = -1;
        m_t0   = 0;
        m_cyc  = 0;
    endtask

    // Advances the model by one clock using this cycle's keys and ready.
    task automatic model_next(input logic [6:0] k, input logic rdy);
        logic [6:0] edges, ev;
        int sel, el;
        bit pop, push;
        edges = k & ~m_prev;
        ev = edges;
        if (m_rpt >= 0 && k[m_rpt] && edges[3:0] == 4'b0) begin
            el = m_cyc - m_t0;
            if (el >= DELAY && (el - DELAY) % RATE == 0) ev[m_rpt] = 1'b1;
        end
        pop = (exp_q.size() > 0) && rdy;
        sel = -1;
        for (int i = 0; i < 7; i++)
            if (sel < 0 && m_pend[prio_order[i]]) sel = prio_order[i];
        push = (sel >= 0) && (exp_q.size() < DEPTH || pop);
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            exp_q.push_back(3'(sel));
            m_pend[sel] = 1'b0;
        end
        for (int i = 0; i < 7; i++) begin
            if (ev[i]) begin
                if (m_pend[i]) m_ovf = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
        if (m_rpt >= 0 && !k[m_rpt]) begin
            m_rpt = -1;
        end else if (edges[3:0] != 4'b0) begin
            for (int d = 3; d >= 0; d--) if (edges[d]) m_rpt = d;
            m_t0 = m_cyc;
        end
        m_prev = k;
        m_cyc++;
    endtask

    task automatic step();
        @(negedge clock);
        chk("valid", cmd_valid, exp_q.size() > 0);
        chk("code", cmd_code, (exp_q.size() > 0) ? exp_q[0] : 3'd0);
        chk("overflow", overflow, m_ovf);
        chk("repeat_active", repeat_active, m_rpt >= 0);
        if (cmd_valid && ready) got_q.push_back(cmd_code);
        model_next(keys, ready);
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        keys  = '0;
        ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_code", cmd_code, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_repeat", repeat_active, 1'b0);
        reset = 1'b0;

        // Single-cycle left press
        ready = 1'b1;
        got_q.delete();
        keys[2] = 1'b1;
        step();
        keys = '0;
        run(8);
        chk_seq("s1", 1, 2);

        // Hold up for 30 cycles: press plus five repeats
        got_q.delete();
        keys[0] = 1'b1;
        run(30);
        keys = '0;
        run(8);
        chk_seq("s2", 6, 0, 0, 0, 0, 0, 0);

        // Simultaneous enter, space, right
        got_q.delete();
        keys = 7'b101_1000;
        step();
        keys = '0;
        run(6);
        chk_seq("s3", 3, 6, 4, 3);

        // Stalled consumer: fill FIFO, hold one pending, then merge into it
        ready = 1'b0;
        keys = 7'b000_0100; step();
        keys = 7'b000_1000; step();
        keys = 7'b000_0001; step();
        keys = 7'b000_0010; step();
        keys = 7'b001_0000; step();
        keys = '0;          step();
        keys = 7'b001_0000; step();
        keys = '0;
        run(2);
        chk("s4_overflow", overflow, 1'b1);
        chk("s4_head", cmd_code, 3'd2);
        got_q.delete();
        ready = 1'b1;
        run(8);
        chk_seq("s4", 5, 2, 3, 0, 1, 4);

        // Right pressed while down is held restarts the repeat timer on right
        got_q.delete();
        keys[1] = 1'b1;
        run(8);
        keys[3] = 1'b1;
        run(14);
        keys = '0;
        run(8);
        chk_seq("s5", 3, 1, 3, 3);

        // Reset mid-operation with entries queued and repeat running
        ready = 1'b0;
        keys = 7'b000_1101;
        run(4);
        chk("s6_pre_repeat", repeat_active, 1'b1);
        keys = 7'b010_0000;
        reset = 1'b1;
        #1;
        chk("s6_rst_valid", cmd_valid, 1'b0);
        chk("s6_rst_code", cmd_code, 3'd0);
        chk("s6_rst_overflow", overflow, 1'b0);
        chk("s6_rst_repeat", repeat_active, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        ready = 1'b1;
        got_q.delete();
        run(3);
        keys = '0;
        run(6);
        chk_seq("s6", 1, 5);

        // Random key toggling and consumer stalls
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) keys[$urandom_range(0, 6)] ^= 1'b1;
            ready = ($urandom_range(0, 3) != 0);
            step();
        end
        keys  = '0;
        ready = 1'b1;
        run(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
